dma_rr_controller: RTL and testbench

Round-robin DMA controller that shares one ROM-to-RAM byte-copy datapath among NCH requesting channels. Each channel presents a descriptor (source address, destination address, length) with a request. The controller grants one channel at a time, sequences the ROM read and RAM write addresses one byte per clock, and signals per-channel acceptance and completion. It sits between the channel requesters and the shared ROM/RAM pair, replacing ad-hoc start-edge-triggered copy loops with a clocked, arbitrated engine.

---
 rtl/dma_rr_controller.sv | 144 ++++++++++++++
 tb/tb_dma_rr_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dma_rr_controller.sv
// Round-robin DMA engine: one shared ROM-to-RAM byte-copy datapath, NCH requesters.
module dma_rr_controller #(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 8,
  parameter int unsigned DW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*AW-1:0]        src_addr,
  input  logic [NCH*AW-1:0]        dst_addr,
  input  logic [NCH*8-1:0]         len,
  output logic [NCH-1:0]           ack,
  output logic [NCH-1:0]           done,
  output logic                     busy,
  output logic [$clog2(NCH)-1:0]   grant_id,
  output logic [AW-1:0]            rom_addr,
  input  logic [DW-1:0]            rom_data,
  output logic [AW-1:0]            ram_addr,
  output logic [DW-1:0]            ram_wdata,
  output logic                     ram_we
);

  localparam int unsigned IW = $clog2(NCH);

  typedef enum logic [1:0] {StIdle, StCopy, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic [NCH-1:0]  done_q, done_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;

  logic            found;
  logic [IW-1:0]   sel;
  int unsigned     idx;

  // Arbiter: first requesting channel at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(rr_ptr_q) + i) % NCH;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  // Next-state logic: grant in idle, one byte per clock in copy, completion pulse in done.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    done_d      = '0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          src_d      = src_addr[int'(sel)*AW +: AW];
          dst_d      = dst_addr[int'(sel)*AW +: AW];
          len_d      = len[int'(sel)*8 +: 8];
          grant_id_d = sel;
          rr_ptr_d   = IW'((int'(sel) + 1) % NCH);
          ack_d[sel] = 1'b1;
          cnt_d      = 8'd0;
          state_d    = (len[int'(sel)*8 +: 8] != 8'd0) ? StCopy : StDone;
        end
      end
      StCopy: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = dst_q + AW'(cnt_q);
        ram_wdata_d = rom_data;
        cnt_d       = cnt_q + 8'd1;
        if (cnt_q == len_q - 8'd1) state_d = StDone;
      end
      StDone: begin
        done_d[grant_id_q] = 1'b1;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any transfer and clears every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      done_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Outputs: read address is combinational from latched base and count.
  always_comb begin
    ack       = ack_q;
    done      = done_q;
    busy      = (state_q != StIdle);
    grant_id  = grant_id_q;
    rom_addr  = src_q + AW'(cnt_q);
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    ram_we    = ram_we_q;
  end

endmodule

// File: tb/tb_dma_rr_controller.sv
// Directed bench for dma_rr_controller: ROM[i]=i, behavioural RAM, cycle-exact checks.
module tb_dma_rr_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] src_addr, dst_addr, len;
  logic [3:0]  ack, done;
  logic        busy;
  logic [1:0]  grant_id;
  logic [7:0]  rom_addr, rom_data, ram_addr, ram_wdata;
  logic        ram_we;
  logic [7:0]  ram [0:255] = '{default: 8'h00};

  int tests = 0;
  int fails = 0;

  dma_rr_controller #(.NCH(4), .AW(8), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .ack       (ack),
    .done      (done),
    .busy      (busy),
    .grant_id  (grant_id),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we)
  );

  always #5 clk = ~clk;

  assign rom_data = rom_addr;

  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input int ch, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l);
    src_addr[ch*8 +: 8] = s;
    dst_addr[ch*8 +: 8] = d;
    len[ch*8 +: 8]      = l;
  endtask

  // Walks cycles 1..l+2 after a grant edge, checking every output cycle by cycle.
  task automatic run_xfer(input int ch, input int l, input logic [7:0] src,
                          input bit drop, input bit alter);
    logic [7:0] ea;
    for (int c = 1; c <= l + 2; c++) begin
      @(posedge clk); #1;
      if (c == 1 && drop) req = '0;
      if (c == 1 && alter) set_desc(ch, 8'h00, 8'hA0, 8'd7);
      chk($sformatf("ch%0d ack c%0d", ch, c), ack, (c == 1) ? 32'(1 << ch) : 32'd0);
      chk($sformatf("ch%0d done c%0d", ch, c), done, (c == l + 2) ? 32'(1 << ch) : 32'd0);
      chk($sformatf("ch%0d we c%0d", ch, c), ram_we, (c >= 2 && c <= l + 1) ? 32'd1 : 32'd0);
      chk($sformatf("ch%0d busy c%0d", ch, c), busy, (c <= l + 1) ? 32'd1 : 32'd0);
      chk($sformatf("ch%0d gid c%0d", ch, c), grant_id, 32'(ch));
      if (c <= l) begin
        ea = src + 8'(c - 1);
        chk($sformatf("ch%0d rom_addr c%0d", ch, c), rom_addr, ea);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '0; src_addr = '0; dst_addr = '0; len = '0;
    #12;
    chk("rst busy", busy, 0);
    chk("rst ack", ack, 0);
    chk("rst done", done, 0);
    chk("rst we", ram_we, 0);
    chk("rst gid", grant_id, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single transfer ch0
    set_desc(0, 8'h10, 8'h80, 8'd4); req = 4'b0001;
    run_xfer(0, 4, 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("single ram[%0h]", 8'h80 + i), ram[8'h80 + i], 8'h10 + i);

    // Zero length ch1
    set_desc(1, 8'h20, 8'h90, 8'd0); req = 4'b0010;
    run_xfer(1, 0, 8'h20, 1'b1, 1'b0);
    chk("zero ram[90]", ram[8'h90], 8'h00);

    // Wrap-around ch2
    set_desc(2, 8'hFE, 8'hFF, 8'd3); req = 4'b0100;
    run_xfer(2, 3, 8'hFE, 1'b1, 1'b0);
    chk("wrap ram[ff]", ram[8'hFF], 8'hFE);
    chk("wrap ram[00]", ram[8'h00], 8'hFF);
    chk("wrap ram[01]", ram[8'h01], 8'h00);

    // Descriptor change after ack, ch3
    set_desc(3, 8'h30, 8'h60, 8'd3); req = 4'b1000;
    run_xfer(3, 3, 8'h30, 1'b1, 1'b1);
    chk("alter ram[60]", ram[8'h60], 8'h30);
    chk("alter ram[62]", ram[8'h62], 8'h32);
    chk("alter ram[63]", ram[8'h63], 8'h00);
    chk("alter ram[a0]", ram[8'hA0], 8'h00);

    // Round-robin from rr_ptr=0, req held; order 0,1,2,3,0
    for (int k = 0; k < 4; k++) set_desc(k, 8'h50 + 8'(k * 16), 8'hB0 + 8'(k * 4), 8'd2);
    req = 4'b1111;
    run_xfer(0, 2, 8'h50, 1'b0, 1'b0);
    run_xfer(1, 2, 8'h60, 1'b0, 1'b0);
    run_xfer(2, 2, 8'h70, 1'b0, 1'b0);
    run_xfer(3, 2, 8'h80, 1'b0, 1'b0);
    run_xfer(0, 2, 8'h50, 1'b1, 1'b0);
    chk("rr ram[b5]", ram[8'hB5], 8'h61);
    chk("rr ram[bd]", ram[8'hBD], 8'h81);

    // Reset after the third write of a len=10 copy on ch1
    set_desc(1, 8'h40, 8'h20, 8'd10); req = 4'b0010;
    @(posedge clk); #1 req = '0;
    chk("mid ack", ack, 4'b0010);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid busy", busy, 0);
    chk("mid we", ram_we, 0);
    chk("mid gid", grant_id, 0);
    chk("mid rom_addr", rom_addr, 0);
    chk("mid ram_addr", ram_addr, 0);
    chk("mid ram_wdata", ram_wdata, 0);
    chk("mid ack0", ack, 0);
    chk("mid done0", done, 0);
    chk("mid ram[22]", ram[8'h22], 8'h42);
    chk("mid ram[23]", ram[8'h23], 8'h00);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    chk("post-rst done", done, 0);
    set_desc(3, 8'hC0, 8'hD0, 8'd2); req = 4'b1000;
    run_xfer(3, 2, 8'hC0, 1'b1, 1'b0);
    chk("post-rst ram[d1]", ram[8'hD1], 8'hC1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
